rx_buffer_ctrl: RTL
===================

# rx_buffer_ctrl

Parametrised receive buffer controller: accepts words from a sender over a four-phase Request/Ack handshake and stores them in an internal circular buffer. A valid/ready read port drains the buffer. It generalises the fixed 16-bit × 16-entry receive path with configurable width and depth, occupancy flags, a run-time stall/overwrite mode and sticky overflow reporting. It sits between the link receiver and the consumer logic.

## Interface
Parameters:
- DATA_W, 16, word width
- DEPTH, 16, buffer entries; must be a power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH

Ports:
- clk  in  1  clock; everything is on the rising edge
- Reset  in  1  synchronous, active-high reset
- Request  in  1  sender request; data is stable while it is high
- data  in  DATA_W  sender word
- Ack  out  1  handshake acknowledge, registered
- wrap_en  in  1  0 = stall when full, 1 = overwrite oldest; sampled in IDLE only
- rd_valid  out  1  buffer not empty
- rd_ready  in  1  consumer pop request
- rd_data  out  DATA_W  word at read pointer
- count  out  clog2(DEPTH)+1  occupancy, 0..DEPTH
- full / empty / almost_full  out  1 each  occupancy flags
- overflow  out  1  sticky; set on any overwrite
- ovf_clr  in  1  clears overflow
- ovf_cnt  out  16  overwritten-word count (only with RX_BUF_OVF_CNT_EN)

## Operation
- States: IDLE, WRITE, ACK_HOLD.
- IDLE: if Request=1 and (!full or wrap_en=1), capture data into data_q, latch the mode and go to WRITE. If full and wrap_en=0, stay in IDLE with Ack=0; the sender stalls.
- WRITE: mem[wr_ptr]←data_q, wr_ptr+1 mod DEPTH, Ack←1, go to ACK_HOLD.
- ACK_HOLD: hold Ack=1 until Request is sampled 0, then Ack←0 and return to IDLE.
- Pop: when rd_valid and rd_ready, rd_ptr+1 mod DEPTH. Pops are legal in any state.
- count: +1 on a write, −1 on a pop, unchanged when both occur in the same cycle. It never exceeds DEPTH.
- Overwrite happens on a write in WRITE while full with the latched mode = wrap and no pop in that cycle:
  - rd_ptr advances and the oldest word is lost.
  - count stays at DEPTH.
  - overflow←1.
- Write plus pop while full is a normal write, not an overwrite.
- overflow is cleared by ovf_clr or Reset. Set wins over clear in the same cycle.
- Flags: full=(count==DEPTH), empty=(count==0), rd_valid=!empty. All are derived from registered count.
- rd_data = mem[rd_ptr], combinational read. It is undefined while empty.

Reset values:
- state=IDLE, Ack=0
- wr_ptr=rd_ptr=count=0
- empty=1, full=0, almost_full=0, rd_valid=0
- overflow=0, ovf_cnt=0
- Memory contents are not reset.

Reset mid-handshake aborts the transfer and the word is not stored. If Request is still high after Reset, it is accepted as a new word.

## Timing
- Request sampled high in IDLE at edge n → data captured at edge n → write and Ack=1 at edge n+1. Ack is visible 2 cycles after Request is first seen.
- Request sampled low in ACK_HOLD at edge m → Ack=0 after edge m; IDLE at m+1. Minimum 4 cycles per word.
- A written word is visible on rd_valid/rd_data the cycle after the write edge.
- A pop takes effect at the edge where rd_valid&rd_ready are sampled.
- A stall in IDLE releases the cycle after a pop makes full=0.

## Configuration
- RX_BUF_OVF_CNT_EN defined:
  - ovf_cnt increments on each overwrite and saturates at 16'hFFFF.
  - It is cleared by Reset or ovf_clr, and an increment wins over ovf_clr.
- Undefined: the ovf_cnt port is absent and there is no counter logic. The sticky overflow flag is always present.

## Structure
- Shared package rx_buf_pkg holds:
  - state encodings RXB_IDLE=2'd0, RXB_WRITE=2'd1, RXB_ACK_HOLD=2'd2
  - the clog2 helper function
- The default state branch returns to IDLE.
- Sub-module rx_buf_mem (DATA_W, DEPTH): single write port, asynchronous read port, no reset.

## Test plan
- Reset, then 3 handshakes with data 16'hA001..A003 → Ack pulses per handshake; count=3; pops return A001, A002, A003 in order; empty=1 after.
- Fill 16 words with wrap_en=0, then a 17th Request → full=1, Ack stays 0; one pop → 17th word accepted, count=16, overflow=0.
- Full with wrap_en=1, write 16'hBEEF → count=16, oldest word lost, newest read-out last is BEEF, overflow=1; ovf_clr → overflow=0; ovf_cnt=1 when enabled.
- Write and pop in the same cycle at count=5 → count stays 5, pointers both advance.
- Reset asserted in ACK_HOLD with Request held high → Ack=0, count=0 after reset, then the word is re-accepted with Ack 2 cycles later.
- DATA_W=32, DEPTH=4, AFULL_TH=3: write 3 words → almost_full=1, full=0; 4th → full=1; wrap of pointers after 6 writes and 6 pops preserves order.

Source files
------------

// File: rtl/rx_buf_pkg.sv
// -----------------------------------------------------------------------------
// rx_buf_pkg
// Shared definitions for the receive buffer controller.
//   - rxb_state_t : handshake FSM state encodings
//   - clog2()     : ceiling log2, used for pointer/count widths at elaboration
// -----------------------------------------------------------------------------
package rx_buf_pkg;

  typedef enum logic [1:0] {
    RXB_IDLE     = 2'd0,
    RXB_WRITE    = 2'd1,
    RXB_ACK_HOLD = 2'd2
  } rxb_state_t;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_buf_mem.sv
// -----------------------------------------------------------------------------
// rx_buf_mem
// Storage array for the receive buffer: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  mem[i_raddr], combinational
// -----------------------------------------------------------------------------
module rx_buf_mem
  import rx_buf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic [clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W-1:0]         o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// rx_buffer_ctrl
// Receive buffer controller. Words arrive over a four-phase Request/Ack
// handshake and are stored in a circular buffer; a valid/ready port drains it.
// When full, wrap_en selects stalling the sender (0) or overwriting the oldest
// word (1). Overwrites set a sticky overflow flag.
//
// Optional feature macro: RX_BUF_OVF_CNT_EN
//   defined   -> ovf_cnt port present, saturating count of overwritten words
//   undefined -> no ovf_cnt port and no counter logic
//
// Parameters: DATA_W (word width), DEPTH (entries, power of two >= 2),
//             AFULL_TH (almost_full when count >= AFULL_TH)
// Ports:
//   clk          in   clock, rising edge
//   Reset        in   synchronous active-high reset
//   Request      in   sender request (data stable while high)
//   data         in   sender word
//   Ack          out  handshake acknowledge (registered)
//   wrap_en      in   0 = stall when full, 1 = overwrite oldest (sampled in IDLE)
//   rd_valid     out  buffer not empty
//   rd_ready     in   consumer pop request
//   rd_data      out  word at read pointer (undefined while empty)
//   count        out  occupancy 0..DEPTH
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AFULL_TH
//   overflow     out  sticky overwrite flag
//   ovf_clr      in   clears overflow (and ovf_cnt)
//   ovf_cnt      out  overwritten-word count (RX_BUF_OVF_CNT_EN only)
// -----------------------------------------------------------------------------
module rx_buffer_ctrl
  import rx_buf_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    Request,
  input  logic [DATA_W-1:0]       data,
  output logic                    Ack,
  input  logic                    wrap_en,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_W-1:0]       rd_data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    overflow,
  input  logic                    ovf_clr
`ifdef RX_BUF_OVF_CNT_EN
  ,
  output logic [15:0]             ovf_cnt
`endif
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

  rxb_state_t        r_state;
  logic              r_ack;
  logic [DATA_W-1:0] r_data_q;
  logic              r_mode_wrap;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_pop;
  logic w_ovw;
  logic w_mem_we;

  // All flags come from the registered count.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  assign w_wr  = (r_state == RXB_WRITE);
  assign w_pop = !w_empty && rd_ready;

  // A write into a full buffer only loses data when nothing is popped in the
  // same cycle; with a pop it is an ordinary slot exchange.
  assign w_ovw = w_wr && w_full && r_mode_wrap && !w_pop;

  // A reset landing on the WRITE cycle aborts the transfer, so the array is
  // left untouched as well.
  assign w_mem_we = w_wr && !Reset;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= RXB_IDLE;
      r_ack       <= 1'b0;
      r_mode_wrap <= 1'b0;
    end else begin
      case (r_state)
        RXB_IDLE: begin
          // Full with stall mode: leave Request pending until a pop frees a slot.
          if (Request && (!w_full || wrap_en)) begin
            r_data_q    <= data;
            r_mode_wrap <= wrap_en;
            r_state     <= RXB_WRITE;
          end
        end
        RXB_WRITE: begin
          r_ack   <= 1'b1;
          r_state <= RXB_ACK_HOLD;
        end
        RXB_ACK_HOLD: begin
          if (!Request) begin
            r_ack   <= 1'b0;
            r_state <= RXB_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= RXB_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer rollover is the modulo.
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      // An overwrite discards the oldest word by stepping the read pointer.
      if (w_pop || w_ovw) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // Write-only grows the count unless already at DEPTH (overwrite case);
      // write-and-pop leaves it unchanged.
      if (w_wr && !w_pop && !w_full) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - CNT_W'(1);
      end
      // Set wins over clear.
      if (w_ovw) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef RX_BUF_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  // Saturating; an overwrite in the same cycle as ovf_clr takes priority.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_ovf_cnt <= 16'd0;
    end else if (w_ovw) begin
      if (r_ovf_cnt != 16'hFFFF) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end else if (ovf_clr) begin
      r_ovf_cnt <= 16'd0;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  rx_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_data_q),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign Ack         = r_ack;
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= AFULL_C);
  assign rd_valid    = !w_empty;
  assign overflow    = r_overflow;

endmodule
